// File: rtl/ghash_pkg.sv
// ---------------------------------------------------------------------------
// ghash_pkg
// Shared definitions for the GHASH controller and its datapath:
//   - ghash_state_e : controller state encoding
//   - MUX_AAD/MUX_CT/MUX_LEN : datapath block-select codes
//   - GHASH_W       : GHASH block width (always 128)
//   - len_bits()    : block count -> 64-bit bit-length field
//   - gf128_mul()   : GF(2^128) product in GCM bit order
// ---------------------------------------------------------------------------
package ghash_pkg;

  localparam int GHASH_W = 128;

  localparam logic [1:0] MUX_AAD = 2'b00;
  localparam logic [1:0] MUX_CT  = 2'b01;
  localparam logic [1:0] MUX_LEN = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOADH,
    ST_CLRAC,
    ST_CLRS,
    ST_AACC,
    ST_AMUL,
    ST_CACC,
    ST_CMUL,
    ST_LACC,
    ST_LMUL,
    ST_DONE
  } ghash_state_e;

  // Every block is 128 bits, so the bit length is the block count times 128.
  function automatic logic [63:0] len_bits(input logic [63:0] blocks);
    return blocks << 7;
  endfunction

  // GCM multiply: bit 127 of the vector is the x^0 coefficient, so the
  // reduction constant R = 11100001 || 0^120 sits at the top of the word.
  function automatic logic [GHASH_W-1:0] gf128_mul(input logic [GHASH_W-1:0] x,
                                                   input logic [GHASH_W-1:0] y);
    logic [GHASH_W-1:0] z;
    logic [GHASH_W-1:0] v;
    z = '0;
    v = y;
    for (int i = 0; i < GHASH_W; i++) begin
      if (x[GHASH_W-1-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'he1, 120'd0};
      else      v = v >> 1;
    end
    return z;
  endfunction

endpackage

// File: rtl/ghash_top_datapath.sv
// ---------------------------------------------------------------------------
// ghash_top_datapath
// GHASH accumulate/multiply datapath steered by ghash_ctrl.
//   clk          in  clock, rising edge
//   h_reg_data   in  hash subkey H, captured on h_reg_en
//   h_reg_en     in  load H
//   aad_data     in  AAD block   (selected by mux_sel = MUX_AAD)
//   cipher_text  in  CT block    (selected by mux_sel = MUX_CT)
//   length_data  in  len(A)||len(C) block (mux_sel = MUX_LEN)
//   mux_sel      in  block select
//   ac_reg_en    in  AC <= block ^ S
//   ac_clr       in  AC <= 0 (wins over ac_reg_en)
//   s_reg_en     in  S <= gf(H, AC)
//   s_reg_out    out current S; the GHASH value once the controller is done
// Data registers carry no reset: the controller clears AC and S at the
// start of every job before they are used.
// ---------------------------------------------------------------------------
module ghash_top_datapath
  import ghash_pkg::*;
(
  input  logic               clk,
  input  logic [GHASH_W-1:0] h_reg_data,
  input  logic               h_reg_en,
  input  logic [GHASH_W-1:0] aad_data,
  input  logic [GHASH_W-1:0] cipher_text,
  input  logic [GHASH_W-1:0] length_data,
  input  logic [1:0]         mux_sel,
  input  logic               ac_reg_en,
  input  logic               ac_clr,
  input  logic               s_reg_en,
  output logic [GHASH_W-1:0] s_reg_out
);

  logic [GHASH_W-1:0] h_q;
  logic [GHASH_W-1:0] blk_sel;
  logic [GHASH_W-1:0] ac_p0;
  logic [GHASH_W-1:0] s_p1;

  always_comb begin
    blk_sel = aad_data;
    case (mux_sel)
      MUX_CT:  blk_sel = cipher_text;
      MUX_LEN: blk_sel = length_data;
      default: blk_sel = aad_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (h_reg_en) h_q <= h_reg_data;
    // stage p0: accumulate selected block into the running hash
    if (ac_clr)         ac_p0 <= '0;
    else if (ac_reg_en) ac_p0 <= blk_sel ^ s_p1;
    // stage p1: multiply accumulator by H
    if (s_reg_en)       s_p1  <= gf128_mul(h_q, ac_p0);
  end

  assign s_reg_out = s_p1;

endmodule

// File: rtl/ghash_ctrl.sv
// ---------------------------------------------------------------------------
// ghash_ctrl
// Control FSM for ghash_top_datapath. Loads H, clears AC and S, then streams
// N AAD blocks and M ciphertext blocks (2 cycles each: ACC then MUL),
// finishes with the len(A)||len(C) block and raises tag_valid.
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active-low
//   start        in   starts a job from IDLE or DONE
//   aad_blocks   in   AAD block count N, sampled on start
//   ct_blocks    in   CT block count M, sampled on start
//   blk_valid    in   upstream block valid
//   blk_ready    out  block accepted this cycle (AACC/CACC only)
//   blk_data     in   AAD/CT block
//   blk_out      out  blk_data pass-through to the datapath
//   length_data  out  {64'(N*128), 64'(M*128)}, registered on start
//   mux_sel      out  datapath block select
//   h_reg_en     out  load H
//   ac_reg_en    out  accumulator capture
//   ac_clr       out  accumulator clear
//   s_reg_en     out  S register capture
//   busy         out  1 in every state except IDLE
//   tag_valid    out  1 in DONE
// Outputs are registered from the next state so they line up with the state
// they belong to; ac_reg_en alone combines the registered ready with
// blk_valid, because acceptance depends on this cycle's valid.
// ---------------------------------------------------------------------------
module ghash_ctrl
  import ghash_pkg::*;
#(
  parameter int WIDTH = GHASH_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] aad_blocks,
  input  logic [CNT_W-1:0] ct_blocks,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [WIDTH-1:0] blk_data,
  output logic [WIDTH-1:0] blk_out,
  output logic [WIDTH-1:0] length_data,
  output logic [1:0]       mux_sel,
  output logic             h_reg_en,
  output logic             ac_reg_en,
  output logic             ac_clr,
  output logic             s_reg_en,
  output logic             busy,
  output logic             tag_valid
);

  ghash_state_e     state;
  ghash_state_e     state_nxt;
  logic [CNT_W-1:0] n_cnt;
  logic [CNT_W-1:0] n_nxt;
  logic [CNT_W-1:0] m_cnt;
  logic [CNT_W-1:0] m_nxt;
  logic             len_acc;
  logic             start_ok;

  // A new job may begin from IDLE or from DONE; anywhere else start is dropped.
  assign start_ok = start && (state == ST_IDLE || state == ST_DONE);

  always_comb begin
    state_nxt = state;
    n_nxt     = n_cnt;
    m_nxt     = m_cnt;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_nxt = ST_LOADH;
          n_nxt     = aad_blocks;
          m_nxt     = ct_blocks;
        end
      end
      ST_LOADH: state_nxt = ST_CLRAC;
      ST_CLRAC: state_nxt = ST_CLRS;
      ST_CLRS: begin
        if (n_cnt != '0)      state_nxt = ST_AACC;
        else if (m_cnt != '0) state_nxt = ST_CACC;
        else                  state_nxt = ST_LACC;
      end
      ST_AACC: if (blk_valid) state_nxt = ST_AMUL;
      ST_AMUL: begin
        // Guarded so a stray entry with a zero count cannot wrap the counter.
        if (n_cnt != '0) n_nxt = n_cnt - 1'b1;
        if (n_cnt > 1)        state_nxt = ST_AACC;
        else if (m_cnt != '0) state_nxt = ST_CACC;
        else                  state_nxt = ST_LACC;
      end
      ST_CACC: if (blk_valid) state_nxt = ST_CMUL;
      ST_CMUL: begin
        if (m_cnt != '0) m_nxt = m_cnt - 1'b1;
        if (m_cnt > 1) state_nxt = ST_CACC;
        else           state_nxt = ST_LACC;
      end
      ST_LACC: state_nxt = ST_LMUL;
      ST_LMUL: state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      n_cnt       <= '0;
      m_cnt       <= '0;
      length_data <= '0;
      mux_sel     <= MUX_AAD;
      blk_ready   <= 1'b0;
      h_reg_en    <= 1'b0;
      ac_clr      <= 1'b0;
      s_reg_en    <= 1'b0;
      len_acc     <= 1'b0;
      busy        <= 1'b0;
      tag_valid   <= 1'b0;
    end else begin
      state <= state_nxt;
      n_cnt <= n_nxt;
      m_cnt <= m_nxt;
      if (start_ok)
        length_data <= WIDTH'({len_bits(64'(aad_blocks)), len_bits(64'(ct_blocks))});
      // mux_sel changes only on entry to an ACC state, so it holds through
      // the following MUL state.
      case (state_nxt)
        ST_AACC: mux_sel <= MUX_AAD;
        ST_CACC: mux_sel <= MUX_CT;
        ST_LACC: mux_sel <= MUX_LEN;
        default: mux_sel <= mux_sel;
      endcase
      blk_ready <= (state_nxt == ST_AACC) || (state_nxt == ST_CACC);
      h_reg_en  <= (state_nxt == ST_LOADH);
      ac_clr    <= (state_nxt == ST_CLRAC);
      s_reg_en  <= (state_nxt == ST_CLRS) || (state_nxt == ST_AMUL) ||
                   (state_nxt == ST_CMUL) || (state_nxt == ST_LMUL);
      len_acc   <= (state_nxt == ST_LACC);
      busy      <= (state_nxt != ST_IDLE);
      tag_valid <= (state_nxt == ST_DONE);
    end
  end

  assign ac_reg_en = len_acc || (blk_ready && blk_valid);
  assign blk_out   = blk_data;

endmodule

// File: tb/tb_ghash_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ghash_ctrl
// Bench for ghash_ctrl driving ghash_top_datapath. A reference GHASH built on
// a carry-less product with explicit polynomial reduction supplies the
// expected tag; a per-cycle monitor checks the controller against a job-level
// model (busy/tag timing, block order, select codes, enable exclusivity).
// Cycle numbers reported below count the start cycle as cycle 1.
// ---------------------------------------------------------------------------
module tb_ghash_ctrl;
  import ghash_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [15:0]  aad_blocks;
  logic [15:0]  ct_blocks;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic [127:0] blk_out;
  logic [127:0] length_data;
  logic [1:0]   mux_sel;
  logic         h_reg_en, ac_reg_en, ac_clr, s_reg_en, busy, tag_valid;
  logic [127:0] h_reg_data;
  logic [127:0] s_reg_out;

  ghash_ctrl #(.WIDTH(128), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .aad_blocks(aad_blocks),
    .ct_blocks(ct_blocks), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_out(blk_out), .length_data(length_data),
    .mux_sel(mux_sel), .h_reg_en(h_reg_en), .ac_reg_en(ac_reg_en),
    .ac_clr(ac_clr), .s_reg_en(s_reg_en), .busy(busy), .tag_valid(tag_valid)
  );

  ghash_top_datapath dp (
    .clk(clk), .h_reg_data(h_reg_data), .h_reg_en(h_reg_en),
    .aad_data(blk_out), .cipher_text(blk_out), .length_data(length_data),
    .mux_sel(mux_sel), .ac_reg_en(ac_reg_en), .ac_clr(ac_clr),
    .s_reg_en(s_reg_en), .s_reg_out(s_reg_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string nm, input logic [127:0] act,
                              input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // ---------------- reference GHASH ----------------
  function automatic logic [127:0] rev128(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = v[127-i];
    return r;
  endfunction

  // Reverse into ordinary polynomial order, carry-less multiply, reduce
  // modulo x^128 + x^7 + x^2 + x + 1, reverse back.
  function automatic logic [127:0] gf_ref(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] p;
    logic [127:0] ra, rb;
    p  = '0;
    ra = rev128(a);
    rb = rev128(b);
    for (int i = 0; i < 128; i++)
      if (rb[i]) p = p ^ (256'(ra) << i);
    for (int k = 254; k >= 128; k--)
      if (p[k]) p = p ^ (256'h1_0000_0000_0000_0000_0000_0000_0000_0087 << (k - 128));
    return rev128(p[127:0]);
  endfunction

  logic [127:0] blk_mem [16];

  function automatic logic [127:0] len_model(input int n, input int m);
    return {64'(n) * 64'd128, 64'(m) * 64'd128};
  endfunction

  function automatic logic [127:0] ghash_model(input logic [127:0] h, input int n, input int m);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < n + m; i++) y = gf_ref(y ^ blk_mem[i], h);
    y = gf_ref(y ^ len_model(n, m), h);
    return y;
  endfunction

  // ---------------- job-level monitor ----------------
  int           mstate = 0;   // 0 idle, 1 running, 2 tag presented
  int           cyc = 0, stalls = 0, acc_cnt = 0, m_n = 0, m_m = 0;
  int           tags_seen = 0, last_cyc = 0, exp_done;
  logic [127:0] m_h, last_tag;
  logic [11:0]  last_mux;
  logic [1:0]   mux_log [$];
  logic [127:0] dat_log [$];

  function automatic void check_job();
    int k;
    logic [1:0]   em;
    logic [127:0] ed;
    logic [11:0]  pk;
    k  = m_n + m_m + 1;
    pk = '0;
    chk("blk_count", 128'(mux_log.size()), 128'(k));
    for (int i = 0; i < mux_log.size() && i < k; i++) begin
      em = (i < m_n) ? MUX_AAD : (i < m_n + m_m) ? MUX_CT : MUX_LEN;
      ed = (i < m_n + m_m) ? blk_mem[i] : len_model(m_n, m_m);
      chk("mux_seq", 128'(mux_log[i]), 128'(em));
      chk("blk_seq", dat_log[i], ed);
      pk = {pk[9:0], mux_log[i]};
    end
    chk("length_data", length_data, len_model(m_n, m_m));
    chk("tag", s_reg_out, ghash_model(m_h, m_n, m_m));
    last_tag = s_reg_out;
    last_cyc = cyc;
    last_mux = pk;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mstate = 0;
        chk("reset_outputs", 128'({busy, tag_valid, blk_ready, h_reg_en, ac_reg_en,
                                   ac_clr, s_reg_en, mux_sel, length_data != 0}), '0);
      end else begin
        if (mstate == 1) cyc++;
        exp_done = 4 + 2 * (m_n + m_m + 1) + stalls;
        chk("one_enable", 128'($countones({h_reg_en, ac_reg_en, ac_clr, s_reg_en}) > 1), '0);
        if (blk_ready) begin
          chk("ready_when_running", 128'(mstate == 1), 128'(1));
          chk("acc_follows_valid", 128'(ac_reg_en), 128'(blk_valid));
          chk("ready_exclusive", 128'({h_reg_en, ac_clr, s_reg_en}), '0);
        end
        chk("busy", 128'(busy), 128'(mstate != 0));
        chk("tag_valid", 128'(tag_valid), 128'((mstate == 2) || (mstate == 1 && cyc == exp_done)));
        if (mstate == 1 && ac_reg_en) begin
          mux_log.push_back(mux_sel);
          dat_log.push_back(mux_sel == MUX_LEN ? length_data : blk_out);
        end
        if (blk_ready && blk_valid) acc_cnt++;
        if (mstate == 1 && blk_ready && !blk_valid) stalls++;
        if (mstate == 1 && tag_valid) begin
          check_job();
          mstate = 2;
          tags_seen++;
        end else if (mstate == 1 && cyc > exp_done + 8) begin
          chk("done_timeout", '0, 128'(1));
          mstate = 0;
        end
        if (start && mstate != 1) begin
          mstate  = 1;
          cyc     = 0;
          stalls  = 0;
          acc_cnt = 0;
          m_n     = int'(aad_blocks);
          m_m     = int'(ct_blocks);
          m_h     = h_reg_data;
          mux_log.delete();
          dat_log.delete();
        end
      end
    end
  end

  // ---------------- upstream block source ----------------
  int stall_at = -1, stall_len = 0, stall_cnt = 0;

  initial begin
    blk_valid = 1'b0;
    blk_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_at >= 0 && acc_cnt == stall_at && blk_ready && stall_cnt < stall_len) begin
        blk_valid = 1'b0;
        stall_cnt++;
      end else begin
        blk_valid = (acc_cnt < m_n + m_m);
      end
      blk_data = blk_mem[acc_cnt % 16];
    end
  end

  // ---------------- directed sequence ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int n, input int m, input logic [127:0] h);
    h_reg_data = h;
    aad_blocks = 16'(n);
    ct_blocks  = 16'(m);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_tag();
    int t0;
    t0 = tags_seen;
    for (int i = 0; i < 300 && tags_seen == t0; i++) tick();
    if (tags_seen == t0) chk("wait_tag_timeout", '0, 128'(1));
  endtask

  localparam logic [127:0] H_TC2   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C_TC2   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] TAG_TC2 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [127:0] H_ALT   = 128'hb83b533708bf535d0aa6e52980d53b78;

  logic [127:0] tag_nostall;

  initial begin
    rst = 1'b0; start = 1'b0; aad_blocks = '0; ct_blocks = '0; h_reg_data = '0;
    for (int i = 0; i < 16; i++)
      blk_mem[i] = {32'h1000_0001 * 32'(i + 1), 32'hA5A5_0000 ^ 32'(i),
                    32'hdead_beef + 32'(i), 32'h0F0F_3C3C ^ (32'(i) << 8)};
    tick(); tick(); tick();
    chk("rst_idle", 128'({busy, tag_valid, blk_ready, h_reg_en, ac_reg_en,
                          ac_clr, s_reg_en, mux_sel}), '0);
    chk("rst_length", length_data, '0);
    rst = 1'b1;
    tick();

    // 1: empty job, only the length block runs
    launch(0, 0, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
    wait_tag();
    chk("t1_tag", last_tag, '0);
    chk("t1_length", length_data, '0);
    chk("t1_cycle", 128'(last_cyc + 1), 128'(7));

    // 2: GCM test case 2
    chk("model_pin_tc2", ghash_model(H_TC2, 0, 0), '0);
    blk_mem[0] = C_TC2;
    chk("model_pin_tc2", ghash_model(H_TC2, 0, 1), TAG_TC2);
    tick();
    launch(0, 1, H_TC2);
    wait_tag();
    chk("t2_tag", last_tag, TAG_TC2);
    chk("t2_length", length_data, 128'h80);

    // 3: N=2, M=3, valid held high
    tick();
    launch(2, 3, H_ALT);
    wait_tag();
    chk("t3_mux_seq", 128'(last_mux), 128'(12'b00_00_01_01_01_10));
    chk("t3_cycle", 128'(last_cyc + 1), 128'(17));
    chk("t3_length", length_data, {64'd256, 64'd384});

    // 4: N=1, M=1 without and with a 4-cycle stall in CACC
    tick();
    launch(1, 1, H_ALT);
    wait_tag();
    tag_nostall = last_tag;
    chk("t4_cycle_nostall", 128'(last_cyc + 1), 128'(11));
    tick();
    stall_at = 1; stall_len = 4; stall_cnt = 0;
    launch(1, 1, H_ALT);
    wait_tag();
    chk("t4_tag_stall", last_tag, tag_nostall);
    chk("t4_cycle_stall", 128'(last_cyc + 1), 128'(15));
    stall_at = -1;

    // 5: reset during CMUL, then a clean rerun
    tick();
    launch(1, 1, H_ALT);
    for (int i = 0; i < 6; i++) tick();
    chk("t5_in_cmul", 128'({s_reg_en, mux_sel}), 128'({1'b1, MUX_CT}));
    rst = 1'b0;
    #1;
    chk("t5_abort_outputs", 128'({busy, tag_valid, blk_ready, h_reg_en, ac_reg_en,
                                  ac_clr, s_reg_en, mux_sel}), '0);
    chk("t5_abort_length", length_data, '0);
    tick(); tick();
    rst = 1'b1;
    tick();
    launch(1, 1, H_ALT);
    wait_tag();
    chk("t5_tag_after_abort", last_tag, tag_nostall);

    // 6: start in AMUL ignored; start in DONE restarts
    tick();
    launch(1, 1, H_ALT);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_in_amul", 128'({s_reg_en, mux_sel}), 128'({1'b1, MUX_AAD}));
    aad_blocks = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    aad_blocks = 16'd1;
    wait_tag();
    chk("t6_cycle_ignored_start", 128'(last_cyc + 1), 128'(11));
    chk("t6_tag", last_tag, tag_nostall);
    launch(0, 0, H_ALT);
    chk("t6_tv_drop", 128'({tag_valid, busy}), 128'(2'b01));
    wait_tag();
    chk("t6_restart_tag", last_tag, '0);
    chk("t6_restart_cycle", 128'(last_cyc + 1), 128'(7));

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
